btn_ctrl_multi: RTL and testbench

Parametrised N-channel successor to the single-button debouncer used for the volume keys.
- Synchronises raw async button inputs and debounces each one.
- Generates per-channel press, release and action strobes.
- Action strobes include auto-repeat after a hold delay.
- Sits between the board button pins and the sys PIO input. Firmware reads levels, or counts action strobes for volume stepping.

---
 rtl/btn_pkg.sv | 28 ++
 rtl/btn_chan.sv | 144 ++++++++++++++
 rtl/btn_ctrl_multi.sv | 39 +++
 tb/tb_btn_ctrl_multi.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the multi-channel button controller:
// repeat-FSM state encoding and elaboration-time width helpers.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // Ceiling log2; returns bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int v;
    int res;
    v   = value - 32'sd1;
    res = 32'sd0;
    while (v > 32'sd0) begin
      res = res + 32'sd1;
      v   = v >>> 1;
    end
    return res;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, debounce, press/release strobes
// and the auto-repeat action generator.
module btn_chan
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int MIN_PULSE_WIDTH = 25000,
  parameter int REPEAT_DELAY    = 12000000,
  parameter int REPEAT_PERIOD   = 3000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  input  logic repeat_en_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic act_o
);

  localparam int DCW = clog2(MIN_PULSE_WIDTH + 1);
  localparam int RCW = clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic           RAW_REL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DCW-1:0] DC_TERM   = DCW'(MIN_PULSE_WIDTH - 1);
  localparam logic [DCW-1:0] DC_ONE    = DCW'(1'b1);
  localparam logic [RCW-1:0] RC_DELAY  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RC_PERIOD = RCW'(REPEAT_PERIOD - 1);
  localparam logic [RCW-1:0] RC_ONE    = RCW'(1'b1);

  logic           sync1_q, sync2_q;
  logic           sample_s, toggle_s, press_evt_s, rel_evt_s;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           lvl_q, lvl_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  rpt_state_e     state_q, state_d;
  logic           press_q, rel_q, act_q, act_d;

  // Synchroniser resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= RAW_REL;
      sync2_q <= RAW_REL;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  assign sample_s = sync2_q ^ RAW_REL;

  always_comb begin
    dcnt_d   = '0;
    lvl_d    = lvl_q;
    toggle_s = 1'b0;
    if (sample_s == lvl_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DC_TERM) begin
      lvl_d    = ~lvl_q;
      toggle_s = 1'b1;
      dcnt_d   = '0;
    end else begin
      dcnt_d = dcnt_q + DC_ONE;
    end
  end

  assign press_evt_s = toggle_s & sample_s;
  assign rel_evt_s   = toggle_s & ~sample_s;

  // Release overrides any repeat action falling due in the same cycle.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    act_d   = 1'b0;
    if (rel_evt_s) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rcnt_d = '0;
          if (press_evt_s) begin
            state_d = ST_DELAY;
            act_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (!repeat_en_i) begin
            rcnt_d = '0;
          end else if (rcnt_q == RC_DELAY) begin
            rcnt_d  = '0;
            act_d   = 1'b1;
            state_d = ST_REPEAT;
          end else begin
            rcnt_d = rcnt_q + RC_ONE;
          end
        end
        ST_REPEAT: begin
          if (!repeat_en_i) begin
            rcnt_d  = '0;
            state_d = ST_DELAY;
          end else if (rcnt_q == RC_PERIOD) begin
            rcnt_d = '0;
            act_d  = 1'b1;
          end else begin
            rcnt_d = rcnt_q + RC_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // Reset mid-hold clears everything without emitting a release strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dcnt_q  <= '0;
      lvl_q   <= 1'b0;
      rcnt_q  <= '0;
      state_q <= ST_IDLE;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      dcnt_q  <= dcnt_d;
      lvl_q   <= lvl_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      press_q <= press_evt_s;
      rel_q   <= rel_evt_s;
      act_q   <= act_d;
    end
  end

  assign btn_o     = lvl_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign act_o     = act_q;

endmodule

// File: rtl/btn_ctrl_multi.sv
// N-channel button controller: one independent btn_chan per button pin.
module btn_ctrl_multi
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int MIN_PULSE_WIDTH = 25000,
  parameter int REPEAT_DELAY    = 12000000,
  parameter int REPEAT_PERIOD   = 3000000
) (
  input  logic               PCLK_i,
  input  logic               reset_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic [NUM_BTN-1:0] repeat_en_i,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] act_o
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .MIN_PULSE_WIDTH (MIN_PULSE_WIDTH),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk_i       (PCLK_i),
      .reset_i     (reset_i),
      .btn_i       (btn_i[g]),
      .repeat_en_i (repeat_en_i[g]),
      .btn_o       (btn_o[g]),
      .press_o     (press_o[g]),
      .release_o   (release_o[g]),
      .act_o       (act_o[g])
    );
  end

endmodule

// File: tb/tb_btn_ctrl_multi.sv
// Randomised scoreboard bench for btn_ctrl_multi against a behavioural model
// built from pin history windows and press/re-enable timestamps.
module tb_btn_ctrl_multi;

  localparam int NB   = 2;
  localparam int AL   = 1;
  localparam int MPW  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int NCYC = 6000;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [NB-1:0] btn_i, repeat_en_i;
  logic [NB-1:0] btn_o, press_o, release_o, act_o;

  always #5 clk = ~clk;

  btn_ctrl_multi #(
    .NUM_BTN(NB), .ACTIVE_LOW(AL), .MIN_PULSE_WIDTH(MPW),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .PCLK_i(clk), .reset_i(reset_i), .btn_i(btn_i), .repeat_en_i(repeat_en_i),
    .btn_o(btn_o), .press_o(press_o), .release_o(release_o), .act_o(act_o)
  );

  typedef struct packed {
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
    logic [NB-1:0] act;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // Model history: pressed-level of the raw pin, reset and enable per cycle.
  bit praw  [NB][NCYC+2];
  bit en_h  [NB][NCYC+2];
  bit lvl_h [NB][NCYC+2];
  bit rst_h [NCYC+2];
  int t0      [NB];
  int lastlow [NB];

  // Synchronised sample seen by the debouncer in cycle c.
  function automatic bit sample(int ch, int c);
    if (c < 2) return 1'b0;
    if (rst_h[c-1] || rst_h[c-2]) return 1'b0;
    return praw[ch][c-2];
  endfunction

  // Expected outputs for cycle t+1 from everything known up to cycle t.
  task automatic model_step(input int t, output exp_t e);
    e = '0;
    for (int ch = 0; ch < NB; ch++) begin
      if (rst_h[t]) begin
        lvl_h[ch][t+1] = 1'b0;
      end else begin
        bit all_diff, lo, ln;
        int base, d;
        all_diff = 1'b1;
        for (int k = 0; k < MPW; k++)
          if (sample(ch, t - k) == lvl_h[ch][t]) all_diff = 1'b0;
        lo = lvl_h[ch][t];
        ln = all_diff ? ~lo : lo;
        lvl_h[ch][t+1] = ln;
        if (lo && !en_h[ch][t]) lastlow[ch] = t;
        e.lvl[ch] = ln;
        e.prs[ch] = ln & ~lo;
        e.rel[ch] = lo & ~ln;
        if (ln && !lo) begin
          t0[ch]      = t + 1;
          lastlow[ch] = t;
          e.act[ch]   = 1'b1;
        end else if (ln && lo) begin
          base = (lastlow[ch] + 1 > t0[ch]) ? lastlow[ch] + 1 : t0[ch];
          d = t + 1 - base;
          e.act[ch] = (d >= RD) && (((d - RD) % RP) == 0);
        end
      end
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare to the scoreboard head.
  exp_t mon_e;
  int   mon_c;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_c = cyc_q.pop_front();
      n_cmp++;
      if ({btn_o, press_o, release_o, act_o} !== mon_e) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got btn=%b press=%b rel=%b act=%b required btn=%b press=%b rel=%b act=%b",
                 mon_c, btn_o, press_o, release_o, act_o, mon_e.lvl, mon_e.prs, mon_e.rel, mon_e.act);
      end
    end else if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_underflow time=%0t got empty required entry", $time);
    end
  end

  bit   pstate [NB];
  int   seg    [NB];
  int   rst_left;
  exp_t e;

  initial begin
    reset_i     = 1'b1;
    btn_i       = (AL != 0) ? {NB{1'b1}} : {NB{1'b0}};
    repeat_en_i = {NB{1'b1}};
    rst_left    = 0;
    for (int ch = 0; ch < NB; ch++) begin
      pstate[ch]  = 1'b0;
      seg[ch]     = 8 + ch * 2;
      t0[ch]      = 0;
      lastlow[ch] = 0;
    end

    for (int t = 0; t < NCYC; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      if (t < 4) begin
        reset_i = 1'b1;
      end else if (rst_left > 0) begin
        reset_i = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 399) == 0) begin
        reset_i  = 1'b1;
        rst_left = $urandom_range(0, 1);
      end else begin
        reset_i = 1'b0;
      end
      for (int ch = 0; ch < NB; ch++) begin
        if (seg[ch] == 0) begin
          pstate[ch] = ~pstate[ch];
          seg[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 45);
        end
        seg[ch]--;
        btn_i[ch] = (AL != 0) ? ~pstate[ch] : pstate[ch];
        if ($urandom_range(0, 49) == 0) repeat_en_i[ch] = ~repeat_en_i[ch];
        praw[ch][t] = pstate[ch];
        en_h[ch][t] = repeat_en_i[ch];
      end
      rst_h[t] = reset_i;
      model_step(t, e);
      exp_q.push_back(e);
      cyc_q.push_back(t + 1);
    end
    done = 1'b1;

    @(posedge clk);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
